// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path and its ALU interface.
package mips_pkg;

    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned ALU_OP_W   = 4;
    localparam int unsigned STATE_W    = 4;
    localparam int unsigned WAIT_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_RD    = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WR    = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11,
        ST_RST       = 4'hF
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Per-state datapath controls; the two gates are qualified by live inputs at the port.
    typedef struct packed {
        logic                mem_read;
        logic                mem_write;
        logic                i_or_d;
        logic                fetch_gate;
        logic                branch_gate;
        logic                pc_write;
        logic [1:0]          pc_source;
        logic                alu_src_a;
        logic [1:0]          alu_src_b;
        logic [ALU_OP_W-1:0] alu_op;
        logic                reg_dst;
        logic                mem_to_reg;
        logic                reg_write;
    } ctrl_t;

    // Moore control word for a state; r_alu_op is the funct-decoded op used in R_EXEC.
    function automatic ctrl_t state_ctrl(input state_t s, input logic [ALU_OP_W-1:0] r_alu_op);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read   = 1'b1;
                c.alu_src_b  = SRC_B_FOUR;
                c.alu_op     = ALU_ADD;
                c.pc_source  = PC_SRC_ALU;
                c.fetch_gate = 1'b1;
            end
            ST_DECODE: begin
                c.alu_src_b = SRC_B_IMM_SH;
                c.alu_op    = ALU_ADD;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            ST_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.alu_op    = r_alu_op;
            end
            ST_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = SRC_B_REG;
                c.alu_op      = ALU_SUB;
                c.pc_source   = PC_SRC_ALUOUT;
                c.branch_gate = 1'b1;
            end
            ST_JUMP: begin
                c.pc_source = PC_SRC_JUMP;
                c.pc_write  = 1'b1;
            end
            ST_ADDI_WB: begin
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // States that wait on mem_ready and run the wait counter.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational R-type funct to ALU operation decoder.
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALU_OP_W-1:0] alu_op_c,
    output logic                valid_c
);

    // Map supported functs; anything else reports invalid with op AND (0000).
    always_comb begin
        alu_op_c = ALU_AND;
        valid_c  = 1'b1;
        case (funct)
            FN_ADD:  alu_op_c = ALU_ADD;
            FN_SUB:  alu_op_c = ALU_SUB;
            FN_AND:  alu_op_c = ALU_AND;
            FN_OR:   alu_op_c = ALU_OR;
            FN_SLT:  alu_op_c = ALU_SLT;
            FN_NOR:  alu_op_c = ALU_NOR;
            default: valid_c  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM with bounded memory-ready waits and sticky error flags.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic       mem_timeout,
    output logic [3:0] state
);

    state_t                state_q;
    state_t                state_d;
    ctrl_t                 ctrl_q;
    ctrl_t                 ctrl_d;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  illegal_q;
    logic                  timeout_q;
    logic                  set_illegal;
    logic                  set_timeout;
    logic                  at_limit;
    logic [ALU_OP_W-1:0]   dec_alu_op;
    logic                  dec_valid;

    mips_alu_decode u_alu_decode (
        .funct    (funct),
        .alu_op_c (dec_alu_op),
        .valid_c  (dec_valid)
    );

    assign at_limit = (wait_cnt == WAIT_CNT_W'(WAIT_LIMIT)) && !mem_ready;

    // Next state, flag events, and the control word for the state being entered.
    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (at_limit) begin
                    set_timeout = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_RTYPE:     state_d = ST_R_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EXEC;
                    default: begin
                        set_illegal = 1'b1;
                        state_d     = ST_FETCH;
                    end
                endcase
            end
            ST_MEM_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end else if (at_limit) begin
                    set_timeout = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_MEM_WR: begin
                if (mem_ready || at_limit) begin
                    set_timeout = !mem_ready;
                    state_d     = ST_FETCH;
                end
            end
            ST_R_EXEC: begin
                if (dec_valid) begin
                    state_d = ST_R_WB;
                end else begin
                    set_illegal = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_ADDI_EXEC: state_d = ST_ADDI_WB;
            default:      state_d = ST_FETCH;
        endcase
        ctrl_d = state_ctrl(state_d, dec_alu_op);
    end

    // State, registered control word, sticky flags and the memory wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RST;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_q | set_illegal;
            timeout_q <= timeout_q | set_timeout;
            if (set_timeout || (state_d != state_q)) begin
                wait_cnt <= '0;
            end else if (is_wait_state(state_q) && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
            end
        end
    end

    assign mem_read    = ctrl_q.mem_read;
    assign mem_write   = ctrl_q.mem_write;
    assign i_or_d      = ctrl_q.i_or_d;
    assign ir_write    = ctrl_q.fetch_gate & mem_ready;
    assign pc_write    = ctrl_q.pc_write
                       | (ctrl_q.fetch_gate & mem_ready)
                       | (ctrl_q.branch_gate & zero);
    assign pc_source   = ctrl_q.pc_source;
    assign alu_src_a   = ctrl_q.alu_src_a;
    assign alu_src_b   = ctrl_q.alu_src_b;
    assign alu_op      = ctrl_q.alu_op;
    assign reg_dst     = ctrl_q.reg_dst;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign reg_write   = ctrl_q.reg_write;
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;
    assign state       = state_q;

endmodule
